// File: rtl/decode_sequencer.sv
// Registered, handshaked instruction decoder for the 9-bit accumulator ISA.
// Stretches ld/st over MEM_LAT cycles, holds a sticky halt and counts retired instructions.
module decode_sequencer #(
    parameter int INSTR_W = 9,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               instr_ready,
    input  logic               resume,
    output logic               ctrl_valid,
    output logic               ctrl_last,
    output logic [3:0]         alu_func,
    output logic [2:0]         alu_spec_func,
    output logic [2:0]         reg_write_val,
    output logic [1:0]         set_ctrl,
    output logic               alu_src,
    output logic               mem_write,
    output logic               mem_read,
    output logic               branch,
    output logic               reg_write,
    output logic               swap_ctrl,
    output logic               jmp_ctrl,
    output logic               done_ctrl,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired_count
);

    typedef enum logic [1:0] {
        RUN,
        MEM,
        HALTED
    } state_t;

    typedef struct packed {
        logic [3:0] alu_func;
        logic [2:0] alu_spec_func;
        logic [2:0] reg_write_val;
        logic [1:0] set_ctrl;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       reg_write;
        logic       swap_ctrl;
        logic       jmp_ctrl;
    } ctrl_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    ctrl_t      ctl;
    ctrl_t      dec;
    logic       dec_halt;
    logic       dec_illegal;
    logic       dec_mem;

    logic [3:0] op;
    logic [1:0] rd;
    logic [2:0] lo;
    logic       unused_bits;

    assign op = instruction[INSTR_W-1:INSTR_W-4];
    assign rd = instruction[4:3];
    assign lo = instruction[2:0];
    // Bits between the opcode and the operand fields carry no meaning.
    assign unused_bits = ^instruction;

    always_comb begin
        dec         = '0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        dec_mem     = 1'b0;
        case (op)
            4'b0000, 4'b0011, 4'b0100, 4'b0101: begin
                dec.alu_func      = op;
                dec.reg_write     = 1'b1;
                dec.reg_write_val = {1'b0, rd};
            end
            4'b0110: begin
                dec.alu_func      = op;
                dec.reg_write     = 1'b1;
                dec.reg_write_val = lo;
            end
            4'b0111: begin
                if (lo == 3'b010) begin
                    dec_halt = 1'b1;
                end else if (lo == 3'b101 || lo == 3'b110 || lo == 3'b111) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec.alu_func      = op;
                    dec.alu_spec_func = lo;
                    dec.reg_write     = 1'b1;
                    dec.reg_write_val = {1'b0, rd};
                end
            end
            4'b1010, 4'b1011: begin
                dec.alu_func      = op;
                dec.alu_src       = 1'b1;
                dec.set_ctrl      = {1'b1, instruction[4]};
                dec.reg_write     = 1'b1;
                dec.reg_write_val = instruction[4] ? 3'b111 : 3'b001;
            end
            4'b1100, 4'b1101: begin
                dec.alu_func = op;
                dec.branch   = 1'b1;
            end
            4'b0001: begin
                // Load writes back only on its last cycle; with no stretch that is now.
                dec.mem_read      = 1'b1;
                dec.reg_write_val = {1'b0, rd};
                dec.reg_write     = (MEM_LAT == 1);
                dec_mem           = 1'b1;
            end
            4'b0010: begin
                dec.mem_write = 1'b1;
                dec_mem       = 1'b1;
            end
            4'b1001: begin
                dec.reg_write = 1'b1;
                dec.swap_ctrl = 1'b1;
            end
            4'b1110: begin
                dec.jmp_ctrl = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            cnt           <= '0;
            ctl           <= '0;
            instr_ready   <= 1'b0;
            ctrl_valid    <= 1'b0;
            ctrl_last     <= 1'b0;
            done_ctrl     <= 1'b0;
            illegal       <= 1'b0;
            retired_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    instr_ready <= 1'b1;
                    ctrl_valid  <= 1'b0;
                    ctrl_last   <= 1'b0;
                    illegal     <= 1'b0;
                    ctl         <= '0;
                    if (instr_valid && instr_ready) begin
                        ctrl_valid <= 1'b1;
                        ctrl_last  <= 1'b1;
                        ctl        <= dec;
                        if (dec_illegal) begin
                            illegal <= 1'b1;
                        end else begin
                            retired_count <= retired_count + CNT_W'(1);
                            if (dec_halt) begin
                                state       <= HALTED;
                                done_ctrl   <= 1'b1;
                                instr_ready <= 1'b0;
                            end else if (dec_mem && MEM_LAT > 1) begin
                                state       <= MEM;
                                cnt         <= LAT_M1;
                                instr_ready <= 1'b0;
                                ctrl_last   <= 1'b0;
                            end
                        end
                    end
                end
                MEM: begin
                    cnt <= cnt - 4'd1;
                    // Final cycle returns to RUN so a new accept can overlap it.
                    if (cnt == 4'd1) begin
                        state         <= RUN;
                        ctrl_last     <= 1'b1;
                        instr_ready   <= 1'b1;
                        ctl.reg_write <= ctl.mem_read;
                    end
                end
                HALTED: begin
                    ctrl_valid <= 1'b0;
                    ctrl_last  <= 1'b0;
                    ctl        <= '0;
                    if (resume) begin
                        state       <= RUN;
                        done_ctrl   <= 1'b0;
                        instr_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign alu_func      = ctl.alu_func;
    assign alu_spec_func = ctl.alu_spec_func;
    assign reg_write_val = ctl.reg_write_val;
    assign set_ctrl      = ctl.set_ctrl;
    assign alu_src       = ctl.alu_src;
    assign mem_write     = ctl.mem_write;
    assign mem_read      = ctl.mem_read;
    assign branch        = ctl.branch;
    assign reg_write     = ctl.reg_write;
    assign swap_ctrl     = ctl.swap_ctrl;
    assign jmp_ctrl      = ctl.jmp_ctrl;

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: directed scenarios plus random traffic against a
// queue-based model of expected per-cycle outputs.
module tb_decode_sequencer;

    localparam int TB_LAT = 3;
    localparam int TB_CNT = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic [8:0]        instruction;
    logic              instr_ready;
    logic              resume;
    logic              ctrl_valid;
    logic              ctrl_last;
    logic [3:0]        alu_func;
    logic [2:0]        alu_spec_func;
    logic [2:0]        reg_write_val;
    logic [1:0]        set_ctrl;
    logic              alu_src;
    logic              mem_write;
    logic              mem_read;
    logic              branch;
    logic              reg_write;
    logic              swap_ctrl;
    logic              jmp_ctrl;
    logic              done_ctrl;
    logic              illegal;
    logic [TB_CNT-1:0] retired_count;

    decode_sequencer #(
        .INSTR_W(9),
        .MEM_LAT(TB_LAT),
        .CNT_W  (TB_CNT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .instr_ready  (instr_ready),
        .resume       (resume),
        .ctrl_valid   (ctrl_valid),
        .ctrl_last    (ctrl_last),
        .alu_func     (alu_func),
        .alu_spec_func(alu_spec_func),
        .reg_write_val(reg_write_val),
        .set_ctrl     (set_ctrl),
        .alu_src      (alu_src),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .branch       (branch),
        .reg_write    (reg_write),
        .swap_ctrl    (swap_ctrl),
        .jmp_ctrl     (jmp_ctrl),
        .done_ctrl    (done_ctrl),
        .illegal      (illegal),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    // Expected per-cycle control bundle; field order matches obs_o below.
    typedef struct packed {
        logic       valid;
        logic       last;
        logic [3:0] af;
        logic [2:0] sf;
        logic [2:0] rwv;
        logic [1:0] set;
        logic       src;
        logic       mw;
        logic       mr;
        logic       br;
        logic       rw;
        logic       sw;
        logic       jmp;
        logic       ill;
    } out_t;

    out_t obs_o;
    assign obs_o = {ctrl_valid, ctrl_last, alu_func, alu_spec_func, reg_write_val, set_ctrl,
                    alu_src, mem_write, mem_read, branch, reg_write, swap_ctrl, jmp_ctrl, illegal};

    out_t              pend[$];
    bit                halted;
    bit                after_rst;
    logic [TB_CNT-1:0] cnt_m;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, expv);
        end
    endtask

    // Model of one accepted instruction: queues the outputs of each cycle it occupies.
    task automatic accept(input logic [8:0] ins);
        logic [3:0] op;
        logic [1:0] rd;
        logic [2:0] lo;
        out_t       o;
        out_t       m;
        bit         ill;
        bit         hlt;
        op  = ins[8:5];
        rd  = ins[4:3];
        lo  = ins[2:0];
        ill = 1'b0;
        hlt = 1'b0;
        o   = '0;
        o.valid = 1'b1;
        o.last  = 1'b1;
        case (op)
            4'd0, 4'd3, 4'd4, 4'd5: begin o.af = op; o.rw = 1'b1; o.rwv = {1'b0, rd}; end
            4'd6:                   begin o.af = op; o.rw = 1'b1; o.rwv = lo; end
            4'd7: begin
                if (lo == 3'd2) hlt = 1'b1;
                else if (lo >= 3'd5) ill = 1'b1;
                else begin o.af = op; o.sf = lo; o.rw = 1'b1; o.rwv = {1'b0, rd}; end
            end
            4'd10, 4'd11: begin
                o.af = op; o.src = 1'b1; o.set = {1'b1, ins[4]}; o.rw = 1'b1;
                o.rwv = ins[4] ? 3'd7 : 3'd1;
            end
            4'd12, 4'd13: begin o.af = op; o.br = 1'b1; end
            4'd1:  begin o.mr = 1'b1; o.rwv = {1'b0, rd}; end
            4'd2:  o.mw = 1'b1;
            4'd9:  begin o.rw = 1'b1; o.sw = 1'b1; end
            4'd14: o.jmp = 1'b1;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            o = '0;
            o.valid = 1'b1;
            o.last  = 1'b1;
            o.ill   = 1'b1;
            pend.push_back(o);
        end else begin
            cnt_m = cnt_m + 1'b1;
            if (hlt) begin
                pend.push_back(o);
                halted = 1'b1;
            end else if (op == 4'd1 || op == 4'd2) begin
                for (int i = 1; i <= TB_LAT; i++) begin
                    m = o;
                    m.last = (i == TB_LAT);
                    if (op == 4'd1) m.rw = (i == TB_LAT);
                    pend.push_back(m);
                end
            end else begin
                pend.push_back(o);
            end
        end
    endtask

    // One cycle: check outputs of the current cycle, drive inputs, advance the model.
    task automatic step(input bit rst, input bit v, input logic [8:0] ins, input bit res);
        out_t cur;
        bit   rdy;
        cur = '0;
        if (pend.size() > 0) cur = pend.pop_front();
        rdy = !after_rst && !halted && (pend.size() == 0);
        check("ctrl", 32'(obs_o), 32'(cur));
        check("ready", 32'(instr_ready), 32'(rdy));
        check("done", 32'(done_ctrl), 32'(halted));
        check("count", 32'(retired_count), 32'(cnt_m));
        reset       = rst;
        instr_valid = v;
        instruction = ins;
        resume      = res;
        if (rst) begin
            pend.delete();
            halted    = 1'b0;
            cnt_m     = '0;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (halted) begin
                if (res) halted = 1'b0;
            end else if (v && rdy) begin
                accept(ins);
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'd0, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        resume      = 1'b0;
        halted      = 1'b0;
        after_rst   = 1'b1;
        cnt_m       = '0;
        @(negedge clock);
        @(negedge clock);

        step(1'b1, 1'b0, 9'd0, 1'b0);
        step(1'b1, 1'b0, 9'd0, 1'b0);
        idle(1);

        // add rd=10
        step(1'b0, 1'b1, 9'b0000_10_000, 1'b0);
        idle(2);

        // ld rd=01 then stf lo=101 held valid until taken
        step(1'b0, 1'b1, 9'b0001_01_000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9'b0110_00_101, 1'b0);
        idle(2);

        // sth and stl
        step(1'b0, 1'b1, 9'b1011_10_000, 1'b0);
        step(1'b0, 1'b1, 9'b1010_01_000, 1'b0);
        idle(1);

        // halt with same-cycle resume (ignored), held valid, then resume
        step(1'b0, 1'b1, 9'b0111_00_010, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 9'b0000_01_000, 1'b0);
        step(1'b0, 1'b1, 9'b0000_01_000, 1'b1);
        step(1'b0, 1'b1, 9'b0000_01_000, 1'b0);
        idle(2);

        // illegal encodings
        step(1'b0, 1'b1, 9'b1111_00_000, 1'b0);
        step(1'b0, 1'b1, 9'b0111_00_110, 1'b0);
        step(1'b0, 1'b1, 9'b1000_11_111, 1'b0);
        idle(1);

        // 16 back-to-back legal accepts wrap the 4-bit counter
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 9'b0011_11_000, 1'b0);
        idle(2);

        // reset in the middle of a store
        step(1'b0, 1'b1, 9'b0010_00_000, 1'b0);
        step(1'b0, 1'b0, 9'd0, 1'b0);
        step(1'b1, 1'b0, 9'd0, 1'b0);
        idle(3);

        // reset while halted
        step(1'b0, 1'b1, 9'b0111_11_010, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 9'd0, 1'b0);
        idle(2);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 9'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        idle(TB_LAT + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
